// File: rtl/alu_issue_pkg.sv
// Shared encodings for the alu_issue slice: ALU operation codes and the
// RV32I opcode/funct constants used by the decoder.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLL = 3'd3,
    ALU_SRL = 3'd4,
    ALU_ADD = 3'd5,
    ALU_SUB = 3'd6
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP / OP-IMM decoder: instr -> {alu_op, use_imm, imm, rd, illegal}.
module alu_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [31:0]          instr,
  output logic [2:0]           alu_op,
  output logic                 use_imm,
  output logic [WORD_SIZE-1:0] imm,
  output logic [4:0]           rd,
  output logic                 illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    op;
  logic       unused_rs1;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign rd         = instr[11:7];
  assign unused_rs1 = ^instr[19:15];
  assign alu_op     = op;

  always_comb begin
    op      = ALU_ADD;
    use_imm = 1'b0;
    imm     = '0;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        imm     = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
        case (funct3)
          F3_ADD: op = ALU_ADD;
          F3_XOR: op = ALU_XOR;
          F3_OR:  op = ALU_OR;
          F3_AND: op = ALU_AND;
          F3_SLL, F3_SR: begin
            // Shift-immediates take only the 5-bit shamt; a non-zero imm[11:5] is SRAI or garbage.
            op  = (funct3 == F3_SLL) ? ALU_SLL : ALU_SRL;
            imm = {{(WORD_SIZE-5){1'b0}}, instr[24:20]};
            if (funct7 != F7_BASE) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op      = ALU_ADD;
      use_imm = 1'b0;
      imm     = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue + writeback stage around the external alu: registered decode/issue,
// then a writeback register with valid/ready backpressure and flush.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [WORD_SIZE-1:0] rs1_data,
  input  logic [WORD_SIZE-1:0] rs2_data,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] arg1,
  output logic [WORD_SIZE-1:0] arg2,
  output logic                 ex_valid,
  input  logic [WORD_SIZE-1:0] alu_result,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 wb_we,
  output logic                 wb_illegal
);

  logic [2:0]           dec_op;
  logic                 dec_use_imm;
  logic [WORD_SIZE-1:0] dec_imm;
  logic [4:0]           dec_rd;
  logic                 dec_illegal;

  alu_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
    .instr   (instr),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  logic                 ex_valid_q,  ex_valid_d;
  logic [2:0]           alu_op_q,    alu_op_d;
  logic [WORD_SIZE-1:0] arg1_q,      arg1_d;
  logic [WORD_SIZE-1:0] arg2_q,      arg2_d;
  logic [4:0]           ex_rd_q,     ex_rd_d;
  logic                 ex_we_q,     ex_we_d;
  logic                 ex_ill_q,    ex_ill_d;
  logic                 wb_valid_q,  wb_valid_d;
  logic [4:0]           wb_rd_q,     wb_rd_d;
  logic [WORD_SIZE-1:0] wb_data_q,   wb_data_d;
  logic                 wb_we_q,     wb_we_d;
  logic                 wb_ill_q,    wb_ill_d;

  logic advance;
  logic accept;

  assign advance  = !wb_valid_q || wb_ready;
  assign in_ready = !ex_valid_q || advance;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    alu_op_d   = alu_op_q;
    arg1_d     = arg1_q;
    arg2_d     = arg2_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    ex_ill_d   = ex_ill_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      alu_op_d   = dec_op;
      arg1_d     = dec_illegal ? '0 : rs1_data;
      arg2_d     = dec_illegal ? '0 : (dec_use_imm ? dec_imm : rs2_data);
      ex_rd_d    = dec_rd;
      ex_we_d    = !dec_illegal && (dec_rd != 5'd0);
      ex_ill_d   = dec_illegal;
    end else if (advance) begin
      ex_valid_d = 1'b0;
    end

    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
    wb_ill_d   = wb_ill_q;
    if (ex_valid_q && advance) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ex_rd_q;
      wb_data_d  = ex_ill_q ? '0 : alu_result;
      wb_we_d    = ex_we_q;
      wb_ill_d   = ex_ill_q;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end

    // Flush only kills the valids; payload registers may load but are never observed as live.
    if (flush) begin
      ex_valid_d = 1'b0;
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      alu_op_q   <= '0;
      arg1_q     <= '0;
      arg2_q     <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_ill_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_ill_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      alu_op_q   <= alu_op_d;
      arg1_q     <= arg1_d;
      arg2_q     <= arg2_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      ex_ill_q   <= ex_ill_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      wb_ill_q   <= wb_ill_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign alu_op     = alu_op_q;
  assign arg1       = arg1_q;
  assign arg2       = arg2_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_we      = wb_we_q;
  assign wb_illegal = wb_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural alu closing the loop.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, wb_ready;
  logic [31:0] instr, rs1_data, rs2_data, arg1, arg2, alu_result, wb_data;
  logic [2:0]  alu_op;
  logic        ex_valid, wb_valid, wb_we, wb_illegal;
  logic [4:0]  wb_rd;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the external alu unit.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = arg1 & arg2;
      3'd1:    alu_result = arg1 | arg2;
      3'd2:    alu_result = arg1 ^ arg2;
      3'd3:    alu_result = arg1 << arg2[4:0];
      3'd4:    alu_result = arg1 >> arg2[4:0];
      3'd5:    alu_result = arg1 + arg2;
      3'd6:    alu_result = arg1 - arg2;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  alu_issue #(.WORD_SIZE(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_op     (alu_op),
    .arg1       (arg1),
    .arg2       (arg2),
    .ex_valid   (ex_valid),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .wb_illegal (wb_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  // Single instruction through an empty pipe with wb_ready = 1.
  task automatic run1(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [2:0] eop, input logic [31:0] ea1,
                      input logic [31:0] ea2, input logic [4:0] erd, input logic [31:0] edata,
                      input logic ewe, input logic eill);
    offer(ins, r1, r2);
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd1);
    chk({tag, ".alu_op"}, {29'd0, alu_op}, {29'd0, eop});
    chk({tag, ".arg1"}, arg1, ea1);
    chk({tag, ".arg2"}, arg2, ea2);
    chk({tag, ".wb_valid0"}, {31'd0, wb_valid}, 32'd0);
    tick();
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, erd});
    chk({tag, ".wb_data"}, wb_data, edata);
    chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, ewe});
    chk({tag, ".wb_illegal"}, {31'd0, wb_illegal}, {31'd0, eill});
    chk({tag, ".ex_drained"}, {31'd0, ex_valid}, 32'd0);
    tick();
    chk({tag, ".wb_drained"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    instr = '0; rs1_data = '0; rs2_data = '0;
    tick();
    tick();
    chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst.arg1", arg1, 32'd0);
    chk("rst.arg2", arg2, 32'd0);
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst.wb_flags", {30'd0, wb_we, wb_illegal}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    //   tag     instr         rs1           rs2  op  arg1          arg2          rd data          we ill
    run1("addi", 32'h00500093, 32'd0,        0,   5,  32'd0,        32'd5,        1, 32'd5,        1, 0);
    run1("sub",  32'h402081B3, 32'd3,        5,   6,  32'd3,        32'd5,        3, 32'hFFFFFFFE, 1, 0);
    run1("srli", 32'h0042D213, 32'h80000000, 0,   4,  32'h80000000, 32'd4,        4, 32'h08000000, 1, 0);
    run1("addim",32'hFFF00113, 32'd10,       0,   5,  32'd10,       32'hFFFFFFFF, 2, 32'd9,        1, 0);
    run1("slt",  32'h003120B3, 32'd7,        9,   5,  32'd0,        32'd0,        1, 32'd0,        0, 1);
    run1("sra",  32'h403150B3, 32'd7,        9,   5,  32'd0,        32'd0,        1, 32'd0,        0, 1);
    run1("addx0",32'h00208033, 32'd1,        2,   5,  32'd1,        32'd2,        0, 32'd3,        0, 0);

    // Full throughput: two back-to-back instructions with wb_ready high.
    offer(32'h00100093, 0, 0);
    tick();
    offer(32'h00200113, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("tput.wb1", wb_data, 32'd1);
    chk("tput.ex2", {31'd0, ex_valid}, 32'd1);
    tick();
    chk("tput.wb2", wb_data, 32'd2);
    chk("tput.wb2v", {31'd0, wb_valid}, 32'd1);
    tick();

    // Backpressure: three offered while wb_ready is low.
    wb_ready = 1'b0;
    offer(32'h00100093, 0, 0);
    tick();
    offer(32'h00200113, 0, 0);
    #1;
    chk("bp.ready2", {31'd0, in_ready}, 32'd1);
    tick();
    offer(32'h00300193, 0, 0);
    #1;
    chk("bp.ready3", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp.hold_wb", wb_data, 32'd1);
    chk("bp.hold_arg2", arg2, 32'd2);
    chk("bp.hold_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp.hold_wb2", wb_data, 32'd1);
    wb_ready = 1'b1;
    #1;
    chk("bp.ready_comb", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.out2", wb_data, 32'd2);
    chk("bp.out2rd", {27'd0, wb_rd}, 32'd2);
    chk("bp.ex3", arg2, 32'd3);
    tick();
    chk("bp.out3", wb_data, 32'd3);
    chk("bp.out3rd", {27'd0, wb_rd}, 32'd3);
    tick();
    chk("bp.empty", {30'd0, ex_valid, wb_valid}, 32'd0);

    // Flush with both stages full and a new offer in the same cycle.
    wb_ready = 1'b0;
    offer(32'h00100093, 0, 0);
    tick();
    offer(32'h00200113, 0, 0);
    tick();
    offer(32'h00300193, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("flush.nothing", {30'd0, ex_valid, wb_valid}, 32'd0);
    run1("post_flush", 32'h00500093, 32'd0, 0, 5, 32'd0, 32'd5, 1, 32'd5, 1, 0);

    // Reset with two instructions in flight.
    wb_ready = 1'b0;
    offer(32'h402081B3, 3, 5);
    tick();
    offer(32'h00500093, 0, 0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    chk("mrst.valids", {30'd0, ex_valid, wb_valid}, 32'd0);
    chk("mrst.alu_op", {29'd0, alu_op}, 32'd0);
    chk("mrst.args", arg1 | arg2, 32'd0);
    chk("mrst.wb", wb_data | {27'd0, wb_rd} | {30'd0, wb_we, wb_illegal}, 32'd0);
    chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("mrst.no_wb", {31'd0, wb_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
